// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM arbiter: FSM states, access owner, default address width.
package sram_arbiter_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam int SRAM_ADDR_W = 20;

  // Counter must hold 0..n-1 and never collapse to zero width.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: MEM-priority grant, fixed-length SRAM access,
// registered read data with a one-cycle ready pulse per port.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_be,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              stall_req,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int CNT_W = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_owner;
  logic              r_we;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_mem_rdata;
  logic              r_if_ready;
  logic              r_mem_ready;

  logic w_access;
  logic w_last;
  logic w_unused;

  assign w_access = (r_state == ACCESS);
  assign w_last   = (r_cnt == CNT_LAST);
  assign w_unused = ^{if_addr[31:ADDR_W+2], if_addr[1:0], mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_owner     <= OWN_IF;
      r_we        <= 1'b0;
      r_be        <= 4'h0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
    end else begin
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          // MEM wins ties: it belongs to the older instruction in the pipe.
          if (mem_req) begin
            r_owner <= OWN_MEM;
            r_addr  <= mem_addr[ADDR_W+1:2];
            r_we    <= mem_we;
            r_be    <= mem_be;
            r_wdata <= mem_wdata;
            r_cnt   <= '0;
            r_state <= ACCESS;
          end else if (if_req) begin
            r_owner <= OWN_IF;
            r_addr  <= if_addr[ADDR_W+1:2];
            r_we    <= 1'b0;
            r_be    <= 4'hF;
            r_cnt   <= '0;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_last) begin
            if (!r_we) begin
              if (r_owner == OWN_MEM) r_mem_rdata <= sram_dq_i;
              else                    r_if_rdata  <= sram_dq_i;
            end
            r_mem_ready <= (r_owner == OWN_MEM);
            r_if_ready  <= (r_owner == OWN_IF);
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Write strobe releases one cycle early so data is held past the we_n rising edge.
  assign sram_ce_n  = ~w_access;
  assign sram_oe_n  = ~(w_access & ~r_we);
  assign sram_we_n  = ~(w_access & r_we & ~w_last);
  assign sram_be_n  = w_access ? (r_we ? ~r_be : 4'h0) : 4'hF;
  assign sram_dq_oe = w_access & r_we;
  assign sram_addr  = r_addr;
  assign sram_dq_o  = r_wdata;

  assign if_rdata  = r_if_rdata;
  assign if_ready  = r_if_ready;
  assign mem_rdata = r_mem_rdata;
  assign mem_ready = r_mem_ready;
  assign stall_req = (if_req & ~r_if_ready) | (mem_req & ~r_mem_ready);

endmodule
